// File: rtl/posit_pkg.sv
// posit_pkg: shared posit widths, special encodings and stage payload types
package posit_pkg;
  localparam int N = 8;
  localparam int ES = 3;
  localparam int RS = $clog2(N);
  localparam int KW = RS + 1;
  typedef struct packed {
    logic sign;
    logic [RS:0] regime;
    logic [ES-1:0] exp;
    logic [N:0] mant;
    logic zero;
    logic nar;
  } posit_unpacked_t;
  typedef struct packed {
    logic [2*N-1:0] body;
    logic sign;
    logic clamp_hi;
    logic clamp_lo;
    logic zero;
    logic nar;
  } posit_body_t;
  function automatic logic [N-1:0] maxpos(input int n);
    return (N'(1) << (n - 1)) - N'(1);
  endfunction
  function automatic logic [N-1:0] minpos(input int n);
    return n > 1 ? N'(1) : N'(0);
  endfunction
  function automatic logic [N-1:0] nar(input int n);
    return N'(1) << (n - 1);
  endfunction
endpackage

// File: rtl/posit_round_pack.sv
// posit_round_pack: round-to-nearest-even, saturate and negate a left-justified posit body
module posit_round_pack
  import posit_pkg::*;
(
  input  posit_body_t      b,
  output logic [N-1:0]     posit
);
  logic [N-2:0] mag;
  logic guard, sticky, up;
  logic [N-1:0] sum, fin;
  // round the top N-1 body bits, keep the magnitude within [minpos, maxpos], then apply sign and specials
  always_comb begin
    mag = b.body[2*N-1 -: N-1];
    guard = b.body[N];
    sticky = |b.body[N-1:0];
    up = guard & (sticky | mag[0]);
    sum = {1'b0, mag} + N'(up);
    fin = b.clamp_hi || sum[N-1] ? maxpos(N) : b.clamp_lo || sum == '0 ? minpos(N) : sum;
    posit = b.nar ? nar(N) : b.zero ? '0 : b.sign ? -fin : fin;
  end
endmodule

// File: rtl/posit_result_encoder.sv
// posit_result_encoder: two-stage valid/ready pipeline packing an unpacked sum into an N-bit posit
module posit_result_encoder
  import posit_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_sign,
  input  logic [RS:0]    in_regime,
  input  logic [ES-1:0]  in_exp,
  input  logic [N:0]     in_mant,
  input  logic           in_zero,
  input  logic           in_nar,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_posit
);
  localparam logic signed [RS:0] KMAX = KW'(N - 2);
  posit_unpacked_t u;
  posit_body_t nxt, s1;
  logic s1_valid, adv, cap, unused_hidden;
  logic signed [RS:0] k, kc;
  logic [RS:0] len, lj;
  logic [N-1:0] rstr, rj, packed_posit;
  logic [2*N+ES-1:0] wide;
  assign u = {in_sign, in_regime, in_exp, in_mant, in_zero, in_nar};
  assign unused_hidden = u.mant[N];
  assign adv = !out_valid || out_ready;
  assign in_ready = !s1_valid || adv;
  // build the regime string, append exponent and fraction, and left-justify; bits past 2N fold into the sticky lsb
  always_comb begin
    k = $signed(u.regime);
    kc = k > KMAX ? KMAX : k < -KMAX ? -KMAX : k;
    len = kc[RS] ? KW'(1) - kc : kc + KW'(2);
    rstr = kc[RS] ? N'(1) : (N'(1) << len) - N'(2);
    cap = len == KW'(N);
    rj = cap ? rstr >> 1 : rstr;
    lj = cap ? KW'(N - 1) : len;
    wide = {rj, u.exp, u.mant[N-1:0]} << (KW'(N) - lj);
    nxt.body = {wide[$bits(wide)-1 -: 2*N-1], |wide[$bits(wide)-2*N:0]};
    nxt.sign = u.sign;
    nxt.clamp_hi = k > KMAX;
    nxt.clamp_lo = k < -KMAX;
    nxt.zero = u.zero;
    nxt.nar = u.nar;
  end
  posit_round_pack u_round (
    .b     (s1),
    .posit (packed_posit)
  );
  // stage 1 holds the shifted body, stage 2 the packed posit; both move whenever the output can take data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1 <= '0;
      out_valid <= 1'b0;
      out_posit <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) s1 <= nxt;
      end
      if (adv) begin
        out_valid <= s1_valid;
        if (s1_valid) out_posit <= packed_posit;
      end
    end
  end
endmodule

// File: tb/tb_posit_result_encoder.sv
// tb_posit_result_encoder: directed and randomized checks against a bit-string posit reference model
module tb_posit_result_encoder;
  logic clk = 0, reset = 1;
  logic in_valid = 0, in_ready, in_sign = 0, in_zero = 0, in_nar = 0;
  logic [3:0] in_regime = 0;
  logic [2:0] in_exp = 0;
  logic [8:0] in_mant = 0;
  logic out_valid, out_ready = 1;
  logic [7:0] out_posit;
  int checks = 0, errors = 0, accepted = 0;
  logic [7:0] exp_q[$];
  logic hold_pending = 0;
  logic [7:0] hold_val = 0;

  posit_result_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_regime (in_regime),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .in_zero   (in_zero),
    .in_nar    (in_nar),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_posit (out_posit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference: write the posit bit string out explicitly, then round on it
  function automatic logic [7:0] ref_posit(input logic s, input int k, input logic [2:0] e,
                                           input logic [8:0] m, input logic z, input logic n);
    bit q[$];
    int kc, mag;
    bit g, st;
    if (n) return 8'h80;
    if (z) return 8'h00;
    kc = k > 6 ? 6 : (k < -6 ? -6 : k);
    if (kc >= 0) begin
      repeat (kc + 1) q.push_back(1'b1);
      q.push_back(1'b0);
    end else begin
      repeat (-kc) q.push_back(1'b0);
      q.push_back(1'b1);
    end
    while (q.size() > 7) void'(q.pop_back());
    for (int i = 2; i >= 0; i--) q.push_back(e[i]);
    for (int i = 7; i >= 0; i--) q.push_back(m[i]);
    mag = 0;
    for (int i = 0; i < 7; i++) mag = mag * 2 + int'(q[i]);
    g = q[7];
    st = 0;
    for (int i = 8; i < q.size(); i++) st |= q[i];
    if (g && (st || (mag % 2 == 1))) mag++;
    if (mag > 127 || k > 6) mag = 127;
    if (mag == 0 || k < -6) mag = 1;
    return s ? 8'(256 - mag) : 8'(mag);
  endfunction

  // Scoreboard and hold-stability monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (reset) hold_pending = 0;
    else begin
      if (hold_pending) check("hold_stable", out_posit, hold_val);
      hold_pending = out_valid && !out_ready;
      hold_val = out_posit;
      if (out_valid && out_ready) begin
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("sb_data", out_posit, exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_posit(in_sign, int'($signed(in_regime)), in_exp, in_mant, in_zero, in_nar));
        accepted++;
      end
    end
  end

  task automatic send_expect(input string tag, input logic s, input int k, input logic [2:0] e,
                             input logic [8:0] m, input logic z, input logic n, input logic [7:0] want);
    int t = 0;
    in_sign = s; in_regime = 4'(k); in_exp = e; in_mant = m; in_zero = z; in_nar = n; in_valid = 1;
    @(negedge clk);
    while (!in_ready && t < 20) begin @(negedge clk); t++; end
    check({tag, "_acc"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 4) begin @(negedge clk); t++; end
    check({tag, "_valid"}, out_valid, 1);
    check(tag, out_posit, want);
    @(posedge clk); #1;
  endtask

  task automatic drive_vec(input int i);
    in_sign = 0; in_regime = 4'(i - 1); in_exp = 3'(i); in_mant = 9'h100 + 9'(i * 16);
    in_zero = 0; in_nar = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, ov, start, cyc;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_posit", out_posit, 0);
    reset = 0;
    #1;
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    send_expect("one_pos",   0, 0, 0, 9'h100, 0, 0, 8'h40);
    send_expect("one_neg",   1, 0, 0, 9'h100, 0, 0, 8'hC0);
    send_expect("1p5_pos",   0, 0, 0, 9'h180, 0, 0, 8'h42);
    send_expect("1p5_neg",   1, 0, 0, 9'h180, 0, 0, 8'hBE);
    send_expect("k1",        0, 1, 0, 9'h100, 0, 0, 8'h60);
    send_expect("tie_odd",   0, 0, 0, 9'h160, 0, 0, 8'h42);
    send_expect("tie_even",  0, 0, 0, 9'h120, 0, 0, 8'h40);
    send_expect("sticky",    0, 0, 0, 9'h121, 0, 0, 8'h41);
    send_expect("sat_k6",    0, 6, 7, 9'h1FF, 0, 0, 8'h7F);
    send_expect("sat_k7",    0, 7, 7, 9'h1FF, 0, 0, 8'h7F);
    send_expect("min_k-6",   0, -6, 0, 9'h100, 0, 0, 8'h01);
    send_expect("min_k-8",   0, -8, 5, 9'h1FF, 0, 0, 8'h01);
    send_expect("min_neg",   1, -8, 0, 9'h100, 0, 0, 8'hFF);
    send_expect("min_neg6",  1, -6, 0, 9'h100, 0, 0, 8'hFF);
    send_expect("nar",       0, 2, 1, 9'h155, 0, 1, 8'h80);
    send_expect("nar_zero",  1, 2, 1, 9'h155, 1, 1, 8'h80);
    send_expect("zero",      1, 3, 2, 9'h1AA, 1, 0, 8'h00);

    start = accepted;
    cyc = 0;
    while (accepted - start < 300 && cyc < 5000) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_sign = 1'($urandom);
      in_regime = 4'($urandom);
      in_exp = 3'($urandom);
      in_mant = {1'b1, 8'($urandom) & ($urandom_range(0, 2) == 0 ? 8'hE0 : 8'hFF)};
      in_zero = $urandom_range(0, 15) == 0;
      in_nar = $urandom_range(0, 15) == 0;
      out_ready = $urandom_range(0, 2) != 0;
      @(posedge clk); #1;
      cyc++;
    end
    check("rand_accepted", accepted - start, 300);
    in_valid = 0;
    out_ready = 1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 10) begin @(posedge clk); #1; cyc++; end
    check("rand_drain", exp_q.size(), 0);

    out_ready = 0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      drive_vec(acc);
      in_valid = acc < 4;
      @(negedge clk);
      if (in_ready && in_valid) acc++;
      @(posedge clk); #1;
    end
    check("bp_accepts", acc, 2);
    check("bp_in_ready", in_ready, 0);
    out_ready = 1;
    ov = 0;
    for (int c = 0; c < 4; c++) begin
      drive_vec(acc);
      in_valid = acc < 4;
      @(negedge clk);
      if (out_valid) ov++;
      if (in_ready && in_valid) acc++;
      @(posedge clk); #1;
    end
    in_valid = 0;
    check("bp_all_accepted", acc, 4);
    check("bp_back_to_back", ov, 4);
    repeat (3) @(posedge clk);
    #1;
    check("bp_drain", exp_q.size(), 0);

    out_ready = 0;
    drive_vec(2);
    in_valid = 1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 0;
    check("pre_rst_valid", out_valid, 1);
    #2;
    reset = 1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_posit", out_posit, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    out_ready = 1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    ov = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) ov++;
    end
    check("post_rst_no_stale", ov, 0);
    send_expect("post_rst_one", 0, 0, 0, 9'h100, 0, 0, 8'h40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
